// File: rtl/glyph_row_renderer.sv
// glyph_row_renderer: takes one character code per handshake and walks the
// font ROM rows {char, row} for rows 0..ROWS-1. Each returned row is
// serialized MSB-first as a pixel stream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and the payload stable until that edge.
// Ready may depend on state only. It never depends on the partner's valid.
//
// Debug: state_dbg exposes the FSM state (0=IDLE, 1=FETCH, 2=WAIT, 3=SHIFT).
module glyph_row_renderer #(
  parameter int CHAR_W = 8,
  parameter int ROW_W  = 4,
  parameter int ROWS   = 16,
  parameter int COLS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHAR_W-1:0]       char_in,
  input  logic                    char_valid,
  output logic                    char_ready,
  output logic [CHAR_W+ROW_W-1:0] rom_addr,
  input  logic [COLS-1:0]         rom_data,
  output logic                    pix_out,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [ROW_W-1:0]        pix_row,
  output logic [2:0]              pix_col,
  output logic                    glyph_done,
  output logic [1:0]              state_dbg
);

  localparam int COL_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CHAR_W-1:0]   char_reg;
  logic [ROW_W-1:0]    row_cnt;
  logic [COL_W-1:0]    col_cnt;
  logic [COLS-1:0]     shift_reg;
  logic                col_last;
  logic                row_last;

  // Terminal counts are compared explicitly so the counters never wrap.
  assign col_last = (col_cnt == COL_W'(COLS - 1));
  assign row_last = (row_cnt == ROW_W'(ROWS - 1));

  // The ROM address comes straight from registers, so it is stable in every state.
  assign rom_addr  = {char_reg, row_cnt};
  assign pix_out   = (state == S_SHIFT) & shift_reg[COLS-1];
  assign pix_row   = row_cnt;
  assign pix_col   = col_cnt;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    char_ready = 1'b0;
    pix_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        char_ready = 1'b1;
        if (char_valid) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_SHIFT;
      S_SHIFT: begin
        pix_valid = 1'b1;
        if (pix_ready && col_last) state_nxt = row_last ? S_IDLE : S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: character latch, row/column counters, pixel shifter, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_reg   <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      shift_reg  <= '0;
      glyph_done <= 1'b0;
    end else begin
      glyph_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (char_valid) begin
            char_reg <= char_in;
            row_cnt  <= '0;
          end
        end
        S_WAIT: begin
          shift_reg <= rom_data;
          col_cnt   <= '0;
        end
        S_SHIFT: begin
          if (pix_ready) begin
            shift_reg <= {shift_reg[COLS-2:0], 1'b0};
            if (!col_last) begin
              col_cnt <= col_cnt + COL_W'(1);
            end else if (!row_last) begin
              row_cnt <= row_cnt + ROW_W'(1);
            end else begin
              glyph_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_row_renderer.sv
// Directed bench for glyph_row_renderer with a 1-cycle registered font ROM
// model whose data is {addr[3:0], ~addr[3:0]}.
module tb_glyph_row_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pix_out;
  logic        pix_valid;
  logic        pix_ready;
  logic [3:0]  pix_row;
  logic [2:0]  pix_col;
  logic        glyph_done;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  glyph_row_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .glyph_done (glyph_done),
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Font ROM model: registered read.
  always @(posedge clk) rom_data <= {rom_addr[3:0], ~rom_addr[3:0]};

  // Time limit.
  initial begin
    #400000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Renders one glyph starting from an IDLE negedge. stall enables random
  // backpressure, next_ch/next_valid drive char_* after the accept, and
  // abort_row >= 0 applies rst at (abort_row, col 3).
  task automatic run_glyph(input logic [7:0] ch, input bit stall,
                           input logic [7:0] next_ch, input bit next_valid,
                           input int abort_row);
    int cnt;
    int seen;
    int stalls;
    bit rdy;
    logic [7:0] d;
    check("entry_ready", char_ready, 1);
    char_in    = ch;
    char_valid = 1'b1;
    @(negedge clk);
    cnt  = 0;
    seen = 0;
    char_in    = next_ch;
    char_valid = next_valid;
    for (int r = 0; r < 16; r++) begin
      check("fetch_addr", rom_addr, {ch, r[3:0]});
      check("fetch_pix_valid", pix_valid, 0);
      check("fetch_char_ready", char_ready, 0);
      check("fetch_done_low", glyph_done, 0);
      @(negedge clk); cnt++; if (glyph_done) seen++;
      check("wait_pix_valid", pix_valid, 0);
      @(negedge clk); cnt++; if (glyph_done) seen++;
      d = {r[3:0], ~r[3:0]};
      for (int c = 0; c < 8; c++) begin
        stalls = 0;
        for (int t = 0; t < 8; t++) begin
          check("pix_valid", pix_valid, 1);
          check("pix_out", pix_out, d[7-c]);
          check("pix_col", pix_col, c);
          check("pix_row", pix_row, r);
          if (r == abort_row && c == 3) begin
            rst = 1'b1;
            pix_ready = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_pix_valid", pix_valid, 0);
            check("abort_char_ready", char_ready, 1);
            check("abort_rom_addr", rom_addr, 12'h000);
            check("abort_done", glyph_done, 0);
            check("abort_state", state_dbg, 0);
            check("abort_no_done_seen", seen, 0);
            return;
          end
          rdy = (!stall || stalls >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
          pix_ready = rdy;
          @(negedge clk); cnt++; if (glyph_done) seen++;
          if (rdy) break;
          stalls++;
        end
      end
    end
    if (!stall) check("glyph_cycles", cnt, 160);
    check("end_done", glyph_done, 1);
    check("end_done_count", seen, 1);
    check("end_char_ready", char_ready, 1);
    check("end_pix_valid", pix_valid, 0);
    check("end_rom_addr", rom_addr, {ch, 4'hF});
    pix_ready = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    pix_ready  = 1'b1;

    // Reset, with junk on char_in to show it is ignored.
    @(negedge clk);
    rst = 1'b1;
    char_in = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_char_ready", char_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_rom_addr", rom_addr, 12'h000);
    check("rst_done", glyph_done, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    check("idle_hold_addr", rom_addr, 12'h000);
    check("idle_hold_ready", char_ready, 1);

    // Single glyph, no backpressure.
    run_glyph(8'h21, 1'b0, 8'h00, 1'b0, -1);
    @(negedge clk);
    check("done_one_cycle", glyph_done, 0);
    check("idle_after_glyph", state_dbg, 0);

    // Random backpressure.
    run_glyph(8'h7E, 1'b1, 8'h00, 1'b0, -1);
    @(negedge clk);
    check("bp_done_one_cycle", glyph_done, 0);

    // Back-to-back: 0x42 offered during 0x41 and taken in the done cycle.
    run_glyph(8'h41, 1'b0, 8'h42, 1'b1, -1);
    check("b2b_addr_at_done", rom_addr, 12'h41F);
    run_glyph(8'h42, 1'b0, 8'h00, 1'b0, -1);
    @(negedge clk);

    // Mid-glyph reset at row 7, col 3, then a clean glyph.
    run_glyph(8'h30, 1'b0, 8'h00, 1'b0, 7);
    @(negedge clk);
    check("post_abort_done", glyph_done, 0);
    run_glyph(8'h31, 1'b0, 8'h00, 1'b0, -1);
    @(negedge clk);
    check("final_done_low", glyph_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glyph_row_renderer.md
Name: glyph_row_renderer

Overview:
Consumer side of the font ROM interface. Accepts one character code per handshake and drives 12-bit font ROM addresses {char, row} for rows 0..15. It captures each 8-bit row returned by the synchronous ROM and serializes it MSB-first as a pixel stream with a valid/ready handshake. Sits between the text/character buffer logic and the display pixel path.

Parameters:
CHAR_W, 8, character code width (upper address bits)
ROW_W, 4, row index width (lower address bits)
ROWS, 16, glyph rows per character (must equal 2**ROW_W)
COLS, 8, pixels per row (equals ROM data width)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
char_in  input  CHAR_W  character code to render
char_valid  input  1  char_in valid
char_ready  output  1  block idle, can accept a character
rom_addr  output  CHAR_W+ROW_W  font ROM address {char_reg, row_cnt}
rom_data  input  COLS  font ROM row data, valid 1 cycle after address sampled
pix_out  output  1  current pixel (1 = foreground)
pix_valid  output  1  pix_out valid
pix_ready  input  1  downstream accepts pixel
pix_row  output  ROW_W  row index of current pixel
pix_col  output  3  column index of current pixel (0 = leftmost = data bit 7)
glyph_done  output  1  one-cycle pulse after last pixel of glyph accepted

Behaviour:
- Reset (rst high at a rising edge): state=IDLE, char_reg=0, row_cnt=0, col_cnt=0, shift reg=0, glyph_done=0. After reset: char_ready=1, pix_valid=0, pix_out=0, rom_addr=0x000.
- rst has priority over all other events and aborts a glyph mid-row or mid-fetch with no glyph_done.
- rom_addr = {char_reg, row_cnt}, derived from registers, stable in every state.
- FSM states: IDLE, FETCH, WAIT, SHIFT.
- IDLE: char_ready=1, pix_valid=0. On char_valid&char_ready: char_reg<=char_in, row_cnt<=0, go FETCH. char_in is ignored when no handshake occurs.
- FETCH: ROM samples rom_addr at the end of this cycle; go WAIT.
- WAIT: rom_data is valid. Shift reg<=rom_data, col_cnt<=0, go SHIFT.
- SHIFT: pix_valid=1, pix_out=shift[COLS-1], pix_col=col_cnt, pix_row=row_cnt.
- SHIFT without pix_ready: hold all registers. pix_out, pix_col and pix_row stay stable, and pix_valid stays high.
- SHIFT with pix_ready: shift left by 1, col_cnt++.
- On the handshake with col_cnt==COLS-1:
  - row_cnt<ROWS-1: row_cnt++, go FETCH.
  - row_cnt==ROWS-1: go IDLE, glyph_done<=1 for exactly one cycle (high during the first IDLE cycle).
- A new character may be accepted in the same cycle that glyph_done is high.
- Latency: accept edge, then FETCH, then WAIT. The first pixel is valid 2 cycles after the accept cycle.
- With pix_ready tied high: 10 cycles per row (2 fetch + 8 pixels), 160 cycles per glyph, plus 1 IDLE cycle before the next accept.
- Wrap-around: row_cnt and col_cnt never overflow. Terminal values are compared explicitly. Row 15 never advances to a 17th fetch.
- char_ready=0 in FETCH/WAIT/SHIFT. char_valid in those states is ignored and does not corrupt char_reg.

Test Plan:
- Bench ROM model: 1-cycle registered read, data={addr[3:0], ~addr[3:0]}.
- Reset then idle: after rst pulse -> char_ready=1, pix_valid=0, rom_addr=0x000, glyph_done=0.
- Single glyph, pix_ready=1, char_in=0x21 ("!"):
  - rom_addr steps 0x210..0x21F.
  - Row 0 pixels 0,0,0,0,1,1,1,1 (0x0F); row 5 pixels from 0x5A; row 15 from 0xF0.
  - First pix_valid 2 cycles after accept; glyph_done pulses exactly once, 160 cycles after the first FETCH.
- Backpressure: pix_ready toggles 1,0,0,1 randomly -> pix_out/pix_col/pix_row held while ready=0; pixel sequence identical to the no-stall case; no pixel dropped or duplicated.
- Back-to-back: char_valid held high with 0x41 then 0x42 -> 0x42 accepted in the glyph_done cycle; rom_addr 0x41F then 0x420; char_valid during SHIFT ignored.
- Mid-glyph reset: rst at row 7, col 3 of char 0x30 -> next cycle IDLE, pix_valid=0, rom_addr=0x000, no glyph_done; a subsequent char 0x31 renders correctly from row 0.
